// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter: one bullet-slot pool shared by three shooters.
// Define BULLET_ARB_STATS_EN to add the saturating deny_count output.
module bullet_slot_arbiter #(
  parameter int NUM_SLOTS = 5,
  parameter int NUM_REQ   = 3,
  parameter int LIFE_W    = 8,
  parameter int MAX_LIFE  = 180,
  parameter int COOLDOWN  = 6
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   clear,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_SLOTS-1:0]   slot_release,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             gnt_slot,
  output logic [NUM_SLOTS-1:0]   slot_busy,
  output logic [2*NUM_SLOTS-1:0] slot_owner,
  output logic                   pool_full
`ifdef BULLET_ARB_STATS_EN
  ,
  output logic [15:0]            deny_count
`endif
);

  localparam logic ST_FREE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam int PW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CD_W =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [PW-1:0] LAST_REQ =
    PW'(NUM_REQ - 1);
  localparam logic [LIFE_W-1:0] LIFE_INIT =
    LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] LIFE_ONE =
    LIFE_W'(1);
  localparam logic [CD_W-1:0] CD_INIT =
    CD_W'(COOLDOWN);

  logic [NUM_SLOTS-1:0] st;
  logic [LIFE_W-1:0]    life [NUM_SLOTS];
  logic [CD_W-1:0]      cd [NUM_REQ];
  logic [PW-1:0]        ptr;

  logic [1:0]           fsync;
  logic                 fprev;
  logic                 tick;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_SLOTS-1:0] free_now;
  logic [NUM_SLOTS-1:0] expire;

  logic                 found_hi;
  logic                 found_lo;
  logic [PW-1:0]        win_hi;
  logic [PW-1:0]        win_lo;
  logic                 found_r;
  logic [PW-1:0]        win;
  logic [PW-1:0]        ptr_nxt;

  logic                 found_s;
  logic [2:0]           win_slot;
  logic                 grant_now;

  // Frame reference: two-flop synchronizer plus edge memory.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync <= 2'b00;
      fprev <= 1'b0;
    end else begin
      fsync <= {fsync[0], frame_clk};
      fprev <= fsync[1];
    end
  end

  // Single-cycle tick on the synchronized rising edge.
  always_comb begin
    tick = fsync[1] & ~fprev;
  end

  // Busy flags follow slot state; pool is full when every slot is active.
  always_comb begin
    slot_busy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_busy[i] = (st[i] == ST_ACTIVE);
    end
    pool_full = &slot_busy;
  end

  // A slot being released this cycle is not offered until next cycle.
  always_comb begin
    free_now = ~slot_busy & ~slot_release;
  end

  // Lifetime expiry fires on the tick that would take life to zero.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      expire[i] = tick && (st[i] == ST_ACTIVE)
                  && (life[i] == LIFE_ONE);
    end
  end

  // Requesters still cooling down or granted right now are skipped.
  always_comb begin
    elig = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      elig[r] = req[r] && (cd[r] == '0) && !gnt[r];
    end
  end

  // Round-robin: lowest eligible at/after ptr, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (elig[r]) begin
        if (r >= int'(ptr)) begin
          found_hi = 1'b1;
          win_hi   = PW'(r);
        end else begin
          found_lo = 1'b1;
          win_lo   = PW'(r);
        end
      end
    end
    found_r = found_hi | found_lo;
    win     = found_hi ? win_hi : win_lo;
    if (win == LAST_REQ) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = win + PW'(1);
    end
  end

  // Winner always takes the lowest-index free slot.
  always_comb begin
    found_s  = 1'b0;
    win_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_now[i]) begin
        found_s  = 1'b1;
        win_slot = 3'(i);
      end
    end
    grant_now = found_r & found_s;
  end

  // Per-slot FREE/ACTIVE state, owner and lifetime countdown.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st         <= '0;
      slot_owner <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        life[i] <= '0;
      end
    end else if (clear) begin
      st <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        life[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        unique case (st[i])
          ST_FREE: begin
            if (grant_now && (win_slot == 3'(i))) begin
              st[i]               <= ST_ACTIVE;
              slot_owner[2*i +: 2] <= 2'(win);
              life[i]             <= LIFE_INIT;
            end
          end
          ST_ACTIVE: begin
            if (slot_release[i] || expire[i]) begin
              st[i]   <= ST_FREE;
              life[i] <= '0;
            end else if (tick) begin
              life[i] <= life[i] - LIFE_ONE;
            end
          end
          default: st[i] <= ST_FREE;
        endcase
      end
    end
  end

  // Requester cooldown: loaded on grant, counts down per frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        cd[r] <= '0;
      end
    end else if (clear) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        cd[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (grant_now && (win == PW'(r))) begin
          cd[r] <= CD_INIT;
        end else if (tick && (cd[r] != '0)) begin
          cd[r] <= cd[r] - CD_W'(1);
        end
      end
    end
  end

  // Registered grant pulse, slot index and round-robin pointer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt      <= '0;
      gnt_slot <= '0;
      ptr      <= '0;
    end else if (clear) begin
      gnt <= '0;
    end else if (grant_now) begin
      gnt      <= NUM_REQ'(1) << win;
      gnt_slot <= win_slot;
      ptr      <= ptr_nxt;
    end else begin
      gnt <= '0;
    end
  end

`ifdef BULLET_ARB_STATS_EN
  // Count cycles where someone wanted a slot but none existed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      deny_count <= '0;
    end else if (clear) begin
      deny_count <= '0;
    end else if ((|elig) && pool_full
                 && (deny_count != 16'hFFFF)) begin
      deny_count <= deny_count + 16'd1;
    end
  end
`endif

endmodule
